// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin shared ALU scheduler with valid/ready request and response handshakes
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   req_valid   [NREQ]      requester i has an operation pending
//   req_ready   [NREQ]      one-hot grant to the winning requester (IDLE only)
//   req_a/req_b [NREQ*N]    operands, requester i at [i*N +: N]
//   req_op      [NREQ*2]    opcode (0 add, 1 mul, 2 sub, 3 and), requester i at [i*2 +: 2]
//   resp_valid  result held for the consumer
//   resp_ready  consumer accepts result
//   resp_data   [2N]        ALU result
//   resp_id     [IDW]       requester that issued the operation
//   busy        an operation is in flight
module alu_rr_scheduler #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [2*N-1:0]    resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [2*N-1:0]   resp_data_q, resp_data_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;

  logic             found;
  logic [IDW-1:0]   winner;
  int unsigned      cand;
  logic [NREQ-1:0]  grant;
  logic [2*N-1:0]   a_ext, b_ext, alu_res;

  // Rotating priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    a_ext = {{N{1'b0}}, a_q};
    b_ext = {{N{1'b0}}, b_q};
    case (op_q)
      2'd0:    alu_res = a_ext + b_ext;
      2'd1:    alu_res = a_ext * b_ext;
      2'd2:    alu_res = a_ext - b_ext;
      default: alu_res = a_ext & b_ext;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    grant       = '0;
    case (state_q)
      S_IDLE: begin
        // A grant is always to a valid requester, so a grant is a handshake.
        if (found) begin
          grant[winner] = 1'b1;
          a_d           = req_a[int'(winner)*N +: N];
          b_d           = req_b[int'(winner)*N +: N];
          op_d          = req_op[int'(winner)*2 +: 2];
          id_d          = winner;
          rr_ptr_d      = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_data_d = alu_res;
        resp_id_d   = id_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end

  // Grant is combinational from req_valid, so mask it while reset is held.
  assign req_ready  = rst ? grant : '0;
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed scoreboard bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [2*N-1:0]    resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;

  alu_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   glog_id[$];
  int   glog_cyc[$];
  int   tb_ptr = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'd0:    r = ai + bi;
      2'd1:    r = ai * bi;
      2'd2:    r = ai - bi;
      default: r = ai & bi;
    endcase
    return r[7:0];
  endfunction

  // Monitor: predicts the round-robin winner, pushes expected results on grant,
  // pops and compares on response handshake.
  always @(negedge clk) begin : mon
    int   w;
    int   c;
    exp_t e;
    exp_t got;
    if (!rst) begin
      tb_ptr = 0;
    end else begin
      if (|(req_valid & req_ready)) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (tb_ptr + k) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
        chk("grant_onehot", req_ready, 32'(1) << w);
        e.data = model(req_a[w*4 +: 4], req_b[w*4 +: 4], req_op[w*2 +: 2]);
        e.id   = 2'(w);
        sb.push_back(e);
        glog_id.push_back(w);
        glog_cyc.push_back(cyc);
        tb_ptr = (w + 1) % NREQ;
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          got = sb.pop_front();
          chk("resp_data", resp_data, got.data);
          chk("resp_id", resp_id, got.id);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    req_valid[i]      = v;
    req_a[i*4 +: 4]   = a;
    req_b[i*4 +: 4]   = b;
    req_op[i*2 +: 2]  = op;
  endtask

  task automatic wait_grant(input int i, output int gc);
    bit got = 0;
    gc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[i] && req_valid[i]) begin
        got = 1;
        gc  = cyc;
        break;
      end
    end
    if (!got) chk("grant_timeout", req_ready[i], 1);
  endtask

  task automatic wait_resp(output int rc);
    bit got = 0;
    rc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        rc  = cyc;
        break;
      end
    end
    if (!got) chk("resp_timeout", resp_valid, 1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("idle_timeout", busy, 0);
    @(posedge clk) #1;
  endtask

  task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, output logic [7:0] rd);
    int g, r;
    set_req(i, 1'b1, a, b, op);
    wait_grant(i, g);
    @(posedge clk) #1;
    req_valid[i] = 1'b0;
    wait_resp(r);
    rd = resp_data;
    @(posedge clk) #1;
  endtask

  int g, r;
  logic [7:0] rd, d0;
  logic [1:0] i0;
  int exp_ids[5];

  initial begin : stim
    rst        = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;

    // Power-on reset: outputs idle, no grant even with requests pending.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    @(posedge clk) #1;
    rst        = 1'b1;
    resp_ready = 1'b1;

    // Single multiply from requester 0, latency check.
    set_req(0, 1'b1, 4'hF, 4'hF, 2'd1);
    wait_grant(0, g);
    @(posedge clk) #1;
    req_valid[0] = 1'b0;
    wait_resp(r);
    chk("mul_latency", r - g, 2);
    chk("mul_data", resp_data, 8'hE1);
    chk("mul_id", resp_id, 0);
    @(posedge clk) #1;

    // Arithmetic corner cases from requester 2.
    run_op(2, 4'd3, 4'd5, 2'd2, rd);
    chk("sub_wrap", rd, 8'hFE);
    run_op(2, 4'd9, 4'd8, 2'd0, rd);
    chk("add_carry", rd, 8'h11);
    run_op(2, 4'hC, 4'hA, 2'd3, rd);
    chk("and_data", rd, 8'h08);

    // Backpressure: response held while resp_ready is low.
    resp_ready = 1'b0;
    set_req(3, 1'b1, 4'd7, 4'd6, 2'd1);
    wait_grant(3, g);
    @(posedge clk) #1;
    req_valid[3] = 1'b0;
    set_req(0, 1'b1, 4'd5, 4'd5, 2'd0);
    wait_resp(r);
    d0 = resp_data;
    i0 = resp_id;
    chk("bp_data", d0, 8'h2A);
    chk("bp_id", i0, 3);
    chk("bp_ready0", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data_stable", resp_data, d0);
      chk("bp_id_stable", resp_id, i0);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge clk) #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", resp_valid, 1);
    chk("bp_accept_no_grant", req_ready, 0);
    @(negedge clk);
    chk("bp_resume_grant", req_ready, 4'b0001);
    @(posedge clk) #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // Pointer at 2 with requesters 1 and 3 pending: 3 wins first.
    run_op(1, 4'd2, 4'd3, 2'd1, rd);
    set_req(1, 1'b1, 4'd6, 4'd7, 2'd0);
    set_req(3, 1'b1, 4'd4, 4'd9, 2'd2);
    glog_id.delete();
    glog_cyc.delete();
    for (int n = 0; n < 20 && glog_id.size() < 2; n++) @(negedge clk);
    @(posedge clk) #1;
    req_valid = '0;
    chk("skip_grant_count", glog_id.size(), 2);
    if (glog_id.size() >= 2) begin
      chk("skip_first", glog_id[0], 3);
      chk("skip_second", glog_id[1], 1);
    end
    wait_idle();

    // Reset asserted mid-EXEC aborts the operation.
    set_req(0, 1'b1, 4'd3, 4'd3, 2'd1);
    wait_grant(0, g);
    @(posedge clk) #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_resp_valid", resp_valid, 0);
    req_valid = 4'hF;
    #2 rst = 1'b0;
    #1;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_resp_data", resp_data, 0);
    chk("abort_resp_id", resp_id, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 0);
    sb.delete();
    @(posedge clk) #1;
    req_valid = '0;
    @(posedge clk) #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", resp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(posedge clk) #1;

    // All four requesters continuously valid: 0,1,2,3,0 every 3 cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'(i + 1), 4'(i + 2), 2'(i));
    glog_id.delete();
    glog_cyc.delete();
    for (int n = 0; n < 40 && glog_id.size() < 5; n++) @(negedge clk);
    @(posedge clk) #1;
    req_valid = '0;
    exp_ids = '{0, 1, 2, 3, 0};
    chk("rr_grant_count", glog_id.size(), 5);
    if (glog_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", glog_id[k], exp_ids[k]);
      for (int k = 1; k < 5; k++) chk("rr_interval", glog_cyc[k] - glog_cyc[k-1], 3);
    end
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
